// File: rtl/mult_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe_pkg
// Purpose  : Shared constants and helpers for the mult_pipe_lpm multiplier.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package mult_pipe_pkg;

  localparam int MAX_PIPELINE = 8;
  localparam int MIN_PIPELINE = 1;
  localparam int MIN_WIDTH    = 2;
  localparam int MAX_WIDTH    = 32;
  localparam int EXT_WIDTH    = MAX_WIDTH + 1;

  function automatic int full_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  // Extends a w-bit operand by one bit: sign fill when sgn=1, zero fill otherwise.
  function automatic logic [EXT_WIDTH-1:0] ext_operand(
    input logic [MAX_WIDTH-1:0] v,
    input int                   w,
    input logic                 sgn
  );
    logic                 fill;
    logic [EXT_WIDTH-1:0] r;
    fill = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == w - 1) fill = sgn & v[i];
    end
    for (int i = 0; i < EXT_WIDTH; i++) begin
      r[i] = (i < w) ? v[i] : fill;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe_stage
// Purpose  : Enable-gated data+valid pipeline register, async active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
module mult_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data only loads behind a valid bit so the last good value is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/mult_pipe_lpm.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe_lpm
// Purpose  : Pipelined signed/unsigned multiplier with valid tracking and stall.
//            Define MULT_PIPE_ACCUM_EN for the multiply-accumulate variant.
// Revision : 1.0 - parametrised successor of the fixed 20x20 LPM multiplier
// ============================================================================
module mult_pipe_lpm
  import mult_pipe_pkg::*;
#(
  parameter int WIDTHA   = 20,
  parameter int WIDTHB   = 20,
  parameter int WIDTHP   = 40,
  parameter int PIPELINE = 1
) (
  input  logic              Clock,
  input  logic              Aclr,
  input  logic              ClkEn,
  input  logic              InValid,
  input  logic              Signed,
  input  logic [WIDTHA-1:0] DataA,
  input  logic [WIDTHB-1:0] DataB,
`ifdef MULT_PIPE_ACCUM_EN
  input  logic              AccClr,
`endif
  output logic [WIDTHP-1:0] Result,
  output logic              OutValid
);

  localparam int c_WFULL = full_width(WIDTHA, WIDTHB);
  localparam int c_NDLY  = (PIPELINE > 1) ? PIPELINE - 2 : 0;
  localparam int c_PW    = c_WFULL + 2;

  generate
    if (WIDTHA < MIN_WIDTH || WIDTHA > MAX_WIDTH ||
        WIDTHB < MIN_WIDTH || WIDTHB > MAX_WIDTH) begin : g_bad_width
      $error("mult_pipe_lpm: operand width out of range");
    end
    if (WIDTHP < 1 || WIDTHP > c_WFULL) begin : g_bad_widthp
      $error("mult_pipe_lpm: WIDTHP out of range");
    end
    if (PIPELINE < MIN_PIPELINE || PIPELINE > MAX_PIPELINE) begin : g_bad_pipe
      $error("mult_pipe_lpm: PIPELINE out of range");
    end
  endgenerate

  logic w_clr_in;
`ifdef MULT_PIPE_ACCUM_EN
  assign w_clr_in = AccClr;
`else
  assign w_clr_in = 1'b0;
`endif

  logic              w_mul_valid;
  logic              w_mul_sgn;
  logic              w_mul_clr;
  logic [WIDTHA-1:0] w_mul_a;
  logic [WIDTHB-1:0] w_mul_b;

  // With PIPELINE=1 the only register is the output, so the product is formed from the ports.
  generate
    if (PIPELINE > 1) begin : g_stage1
      logic              r_valid;
      logic              r_sgn;
      logic              r_clr;
      logic [WIDTHA-1:0] r_a;
      logic [WIDTHB-1:0] r_b;

      always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
          r_valid <= 1'b0;
          r_sgn   <= 1'b0;
          r_clr   <= 1'b0;
          r_a     <= '0;
          r_b     <= '0;
        end else if (ClkEn) begin
          r_valid <= InValid;
          if (InValid) begin
            r_sgn <= Signed;
            r_clr <= w_clr_in;
            r_a   <= DataA;
            r_b   <= DataB;
          end
        end
      end

      assign w_mul_valid = r_valid;
      assign w_mul_sgn   = r_sgn;
      assign w_mul_clr   = r_clr;
      assign w_mul_a     = r_a;
      assign w_mul_b     = r_b;
    end else begin : g_no_stage1
      assign w_mul_valid = InValid;
      assign w_mul_sgn   = Signed;
      assign w_mul_clr   = w_clr_in;
      assign w_mul_a     = DataA;
      assign w_mul_b     = DataB;
    end
  endgenerate

  logic [WIDTHA:0]    w_ext_a;
  logic [WIDTHB:0]    w_ext_b;
  logic [c_WFULL-1:0] w_full;

  assign w_ext_a = (WIDTHA + 1)'(ext_operand(MAX_WIDTH'(w_mul_a), WIDTHA, w_mul_sgn));
  assign w_ext_b = (WIDTHB + 1)'(ext_operand(MAX_WIDTH'(w_mul_b), WIDTHB, w_mul_sgn));
  // The exact product fits in c_WFULL bits for both modes, so modular signed math suffices.
  assign w_full  = c_WFULL'($signed(w_ext_a)) * c_WFULL'($signed(w_ext_b));

  logic [c_PW-1:0] w_pay [0:c_NDLY];
  logic            w_vld [0:c_NDLY];

  assign w_pay[0] = {w_mul_clr, w_mul_sgn, w_full};
  assign w_vld[0] = w_mul_valid;

  generate
    for (genvar k = 1; k <= c_NDLY; k++) begin : g_dly
      mult_pipe_stage #(.WIDTH(c_PW)) u_stage (
        .clk     (Clock),
        .rst     (Aclr),
        .i_en    (ClkEn),
        .i_valid (w_vld[k-1]),
        .i_data  (w_pay[k-1]),
        .o_valid (w_vld[k]),
        .o_data  (w_pay[k])
      );
    end
  endgenerate

  logic              w_pre_clr;
  logic              w_pre_sgn;
  logic [c_WFULL-1:0] w_pre_prod;
  logic [WIDTHP-1:0] w_fin_d;
  logic [WIDTHP-1:0] w_fin_q;

  assign {w_pre_clr, w_pre_sgn, w_pre_prod} = w_pay[c_NDLY];

`ifdef MULT_PIPE_ACCUM_EN
  generate
    if (WIDTHP < c_WFULL) begin : g_bad_acc
      $error("mult_pipe_lpm: accumulator needs WIDTHP >= WIDTHA+WIDTHB");
    end
  endgenerate

  logic [WIDTHP-1:0] w_pre_ext;
  assign w_pre_ext = w_pre_sgn ? WIDTHP'($signed(w_pre_prod)) : WIDTHP'(w_pre_prod);
  assign w_fin_d   = (w_pre_clr ? '0 : w_fin_q) + w_pre_ext;
`else
  logic w_unused_ok;
  assign w_unused_ok = w_pre_clr ^ w_pre_sgn ^ (^w_pre_prod);
  assign w_fin_d     = w_pre_prod[c_WFULL-1 -: WIDTHP];
`endif

  mult_pipe_stage #(.WIDTH(WIDTHP)) u_final (
    .clk     (Clock),
    .rst     (Aclr),
    .i_en    (ClkEn),
    .i_valid (w_vld[c_NDLY]),
    .i_data  (w_fin_d),
    .o_valid (OutValid),
    .o_data  (w_fin_q)
  );

  assign Result = w_fin_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_lpm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_pipe_lpm
// Purpose  : Directed self-checking bench for mult_pipe_lpm (PIPELINE=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_pipe_lpm;

  logic        Clock = 1'b0;
  logic        Aclr;
  logic        ClkEn;
  logic        InValid;
  logic        Signed;
  logic [19:0] DataA;
  logic [19:0] DataB;
  logic [39:0] Result;
  logic        OutValid;
`ifdef MULT_PIPE_ACCUM_EN
  logic        acc_clr = 1'b1;
`else
  logic [15:0] result16;
  logic        outvalid16;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  mult_pipe_lpm #(.WIDTHA(20), .WIDTHB(20), .WIDTHP(40), .PIPELINE(3)) dut (
    .Clock    (Clock),
    .Aclr     (Aclr),
    .ClkEn    (ClkEn),
    .InValid  (InValid),
    .Signed   (Signed),
    .DataA    (DataA),
    .DataB    (DataB),
`ifdef MULT_PIPE_ACCUM_EN
    .AccClr   (acc_clr),
`endif
    .Result   (Result),
    .OutValid (OutValid)
  );

`ifndef MULT_PIPE_ACCUM_EN
  mult_pipe_lpm #(.WIDTHA(20), .WIDTHB(20), .WIDTHP(16), .PIPELINE(3)) dut16 (
    .Clock    (Clock),
    .Aclr     (Aclr),
    .ClkEn    (ClkEn),
    .InValid  (InValid),
    .Signed   (Signed),
    .DataA    (DataA),
    .DataB    (DataB),
    .Result   (result16),
    .OutValid (outvalid16)
  );
`endif

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [19:0] a, input logic [19:0] b);
    InValid = v;
    Signed  = s;
    DataA   = a;
    DataB   = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Aclr  = 1'b1;
    ClkEn = 1'b0;
    drive(0, 0, 20'h0, 20'h0);
    repeat (2) tick();
    chk_val("reset_result", Result, 0);
    chk_val("reset_valid", OutValid, 0);
    Aclr  = 1'b0;
    ClkEn = 1'b1;
    tick();

    // -3 * 5, signed; three registers so valid after the second edge following the sample
    drive(1, 1, 20'hFFFFD, 20'h00005);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    chk_val("neg_lat1", OutValid, 0);
    tick();
    chk_val("neg_lat2", OutValid, 0);
    tick();
    chk_val("neg_valid", OutValid, 1);
    chk_val("neg_result", Result, 40'hFFFFFFFFF1);
    tick();
    chk_val("neg_pulse", OutValid, 0);
    chk_val("neg_hold", Result, 40'hFFFFFFFFF1);

    // Same operands, unsigned then signed on consecutive cycles
    drive(1, 0, 20'hFFFFF, 20'hFFFFF);
    tick();
    drive(1, 1, 20'hFFFFF, 20'hFFFFF);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    tick();
    chk_val("uns_max_valid", OutValid, 1);
    chk_val("uns_max", Result, 40'hFFFFE00001);
`ifndef MULT_PIPE_ACCUM_EN
    chk_val("uns_max_p16", result16, 16'hFFFF);
`endif
    tick();
    chk_val("sgn_m1_valid", OutValid, 1);
    chk_val("sgn_m1", Result, 40'h0000000001);
`ifndef MULT_PIPE_ACCUM_EN
    chk_val("sgn_m1_p16", result16, 16'h0000);
`endif

    // Most-negative squared
    drive(1, 1, 20'h80000, 20'h80000);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    tick();
    tick();
    chk_val("minneg_valid", OutValid, 1);
    chk_val("minneg", Result, 40'h4000000000);
`ifndef MULT_PIPE_ACCUM_EN
    chk_val("minneg_p16", result16, 16'h4000);
    chk_val("minneg_p16_valid", outvalid16, 1);
`endif

    // Back-to-back with a two-cycle stall after the second operation
    drive(1, 0, 20'd2, 20'd3);
    tick();
    drive(1, 0, 20'd4, 20'd5);
    tick();
    chk_val("stall_pre_valid", OutValid, 0);
    ClkEn = 1'b0;
    drive(1, 0, 20'd9, 20'd9);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_val("stall_valid", OutValid, 0);
      chk_val("stall_result", Result, 40'h4000000000);
    end
    ClkEn = 1'b1;
    drive(1, 0, 20'd6, 20'd7);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    chk_val("b2b_1_valid", OutValid, 1);
    chk_val("b2b_1", Result, 40'd6);
    ClkEn = 1'b0;
    tick();
    chk_val("freeze_valid", OutValid, 1);
    chk_val("freeze_result", Result, 40'd6);
    ClkEn = 1'b1;
    tick();
    chk_val("b2b_2_valid", OutValid, 1);
    chk_val("b2b_2", Result, 40'd20);
    tick();
    chk_val("b2b_3_valid", OutValid, 1);
    chk_val("b2b_3", Result, 40'd42);
    tick();
    chk_val("b2b_end_valid", OutValid, 0);
    chk_val("b2b_end_hold", Result, 40'd42);

    // Asynchronous clear with operations in flight
    drive(1, 0, 20'd3, 20'd3);
    tick();
    drive(1, 0, 20'd4, 20'd4);
    tick();
    drive(1, 0, 20'd5, 20'd5);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    chk_val("preclr_valid", OutValid, 1);
    chk_val("preclr_result", Result, 40'd9);
    #2;
    Aclr = 1'b1;
    #1;
    chk_val("aclr_result", Result, 0);
    chk_val("aclr_valid", OutValid, 0);
    Aclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val("aclr_flushed", OutValid, 0);
    end
    drive(1, 0, 20'd7, 20'd8);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    tick();
    tick();
    chk_val("recover_valid", OutValid, 1);
    chk_val("recover", Result, 40'd56);

`ifdef MULT_PIPE_ACCUM_EN
    // Accumulate 3*4, +5*6, +(-1)*10
    acc_clr = 1'b1;
    drive(1, 1, 20'd3, 20'd4);
    tick();
    acc_clr = 1'b0;
    drive(1, 1, 20'd5, 20'd6);
    tick();
    drive(1, 1, 20'hFFFFF, 20'd10);
    tick();
    drive(0, 0, 20'h0, 20'h0);
    chk_val("acc_1", Result, 40'd12);
    chk_val("acc_1_valid", OutValid, 1);
    tick();
    chk_val("acc_2", Result, 40'd42);
    tick();
    chk_val("acc_3", Result, 40'd32);
    tick();
    chk_val("acc_end_valid", OutValid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
